core_run_ctrl: RTL and testbench

Synthesizable run controller for Core. It holds Core in reset, releases it on a start command, and gates execution through a clock enable, with optional single-step. It watches the program counter against programmable pass/fail addresses and enforces a cycle limit, latching a PASS/FAIL/TIMEOUT result for the on-board LEDs and for host readout over the UART path.

---
 rtl/core_run_ctrl_pkg.sv | 40 ++++
 rtl/core_run_ctrl.sv | 162 ++++++++++++++++
 tb/tb_core_run_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/core_run_ctrl_pkg.sv
// Shared types and defaults for the Core run controller: FSM state and run
// result encodings plus the LED status helper.
package core_run_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RESET   = 4'd1,
        ST_RUN     = 4'd2,
        ST_PASS    = 4'd3,
        ST_FAIL    = 4'd4,
        ST_TIMEOUT = 4'd5
    } run_state_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'd0,
        RES_PASS    = 2'd1,
        RES_FAIL    = 2'd2,
        RES_TIMEOUT = 2'd3
    } run_result_t;

    localparam int DEF_CYCLE_LIMIT = 1000;
    localparam int DEF_RST_CYCLES  = 4;

    // LEDs are active low: a lit LED marks a set bit of {result, state}.
    function automatic logic [5:0] led_code(input run_result_t res, input run_state_t st);
        return ~{res, st};
    endfunction

    function automatic run_state_t halt_state(input run_result_t res);
        run_state_t st;
        case (res)
            RES_PASS:    st = ST_PASS;
            RES_FAIL:    st = ST_FAIL;
            RES_TIMEOUT: st = ST_TIMEOUT;
            default:     st = ST_IDLE;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/core_run_ctrl.sv
// Run controller for Core: holds it in reset, releases it on start, gates
// execution (optionally single-step) and latches PASS/FAIL/TIMEOUT.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32,
    parameter int CYCLE_LIMIT = DEF_CYCLE_LIMIT,
    parameter int RST_CYCLES  = DEF_RST_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             step_mode,
    input  logic             step,
    input  logic [PC_W-1:0]  pass_addr,
    input  logic [PC_W-1:0]  fail_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             core_rst_n,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic [1:0]       result,
    output logic [CNT_W-1:0] cycle_count,
    output logic [5:0]       leds
);

    localparam int RST_W = $clog2(RST_CYCLES + 1);

    run_state_t        state_r;
    logic [RST_W-1:0]  rst_cnt_r;
    logic [PC_W-1:0]   pass_r;
    logic [PC_W-1:0]   fail_r;

    logic              en_s;
    logic              start_ok_s;
    logic              limit_s;
    logic [CNT_W-1:0]  cnt_nx_s;
    run_result_t       halt_res_s;

    // Core enable: combinational so a step pulse advances Core in the same cycle.
    always_comb begin
        en_s = 1'b0;
        if (state_r == ST_RUN) begin
            if (step_mode) begin
                en_s = step;
            end else begin
                en_s = 1'b1;
            end
        end else begin
            en_s = 1'b0;
        end
    end

    assign core_en = en_s;

    // Start is honoured only when no run is in progress.
    always_comb begin
        start_ok_s = 1'b0;
        if ((state_r == ST_IDLE) || (state_r == ST_PASS) ||
            (state_r == ST_FAIL) || (state_r == ST_TIMEOUT)) begin
            start_ok_s = start;
        end else begin
            start_ok_s = 1'b0;
        end
    end

    // Cycle count after this cycle, saturating; the limit is judged on this value
    // so TIMEOUT reports exactly CYCLE_LIMIT enabled cycles.
    always_comb begin
        cnt_nx_s = cycle_count;
        if (en_s && (cycle_count != {CNT_W{1'b1}})) begin
            cnt_nx_s = cycle_count + CNT_W'(1);
        end else begin
            cnt_nx_s = cycle_count;
        end
        limit_s = (cnt_nx_s == CNT_W'(CYCLE_LIMIT));
    end

    // Run verdict for this cycle, FAIL beating PASS beating TIMEOUT.
    always_comb begin
        halt_res_s = RES_NONE;
        if (pc == fail_r) begin
            halt_res_s = RES_FAIL;
        end else if (pc == pass_r) begin
            halt_res_s = RES_PASS;
        end else if (limit_s) begin
            halt_res_s = RES_TIMEOUT;
        end else begin
            halt_res_s = RES_NONE;
        end
    end

    // Run-control FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rst_cnt_r   <= RST_W'(0);
            pass_r      <= {PC_W{1'b0}};
            fail_r      <= {PC_W{1'b0}};
            core_rst_n  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= RES_NONE;
            cycle_count <= {CNT_W{1'b0}};
            leds        <= led_code(RES_NONE, ST_IDLE);
        end else if (clear) begin
            state_r    <= ST_IDLE;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= RES_NONE;
            leds       <= led_code(RES_NONE, ST_IDLE);
        end else if (start_ok_s) begin
            state_r     <= ST_RESET;
            rst_cnt_r   <= RST_W'(RST_CYCLES - 1);
            pass_r      <= pass_addr;
            fail_r      <= fail_addr;
            core_rst_n  <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            result      <= RES_NONE;
            cycle_count <= {CNT_W{1'b0}};
            leds        <= led_code(RES_NONE, ST_RESET);
        end else begin
            cycle_count <= cnt_nx_s;
            case (state_r)
                ST_RESET: begin
                    if (rst_cnt_r == RST_W'(0)) begin
                        state_r    <= ST_RUN;
                        core_rst_n <= 1'b1;
                        leds       <= led_code(RES_NONE, ST_RUN);
                    end else begin
                        rst_cnt_r <= rst_cnt_r - RST_W'(1);
                    end
                end
                ST_RUN: begin
                    if (halt_res_s != RES_NONE) begin
                        state_r <= halt_state(halt_res_s);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= halt_res_s;
                        leds    <= led_code(halt_res_s, halt_state(halt_res_s));
                    end
                end
                ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                end
                default: begin
                    // Illegal encoding: fall back to a safe idle with Core held in reset.
                    state_r    <= ST_IDLE;
                    core_rst_n <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    result     <= RES_NONE;
                    leds       <= led_code(RES_NONE, ST_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: run verdicts are queued by the stimulus
// and checked by a monitor whenever done rises.
module tb_core_run_ctrl;

    localparam int RST_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, clear, step_mode, step;
    logic [31:0] pass_addr, fail_addr, pc;
    logic        core_rst_n, core_en, busy, done;
    logic [1:0]  result;
    logic [31:0] cycle_count;
    logic [5:0]  leds;

    typedef struct {
        logic [1:0]  res;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_miss = 0;

    core_run_ctrl #(.PC_W(32), .CNT_W(32), .CYCLE_LIMIT(1000), .RST_CYCLES(RST_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .step_mode(step_mode), .step(step), .pass_addr(pass_addr),
        .fail_addr(fail_addr), .pc(pc), .core_rst_n(core_rst_n),
        .core_en(core_en), .busy(busy), .done(done), .result(result),
        .cycle_count(cycle_count), .leds(leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] r, input logic [31:0] c);
        exp_t e;
        e.res = r;
        e.cnt = c;
        sb_q.push_back(e);
    endtask

    // Pulse start and measure how long Core is held in reset.
    task automatic start_run(input logic [31:0] pa, input logic [31:0] fa);
        int k;
        pass_addr = pa;
        fail_addr = fa;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("rst_low_after_start", {63'd0, core_rst_n}, 64'd0);
        k = 0;
        while (!core_rst_n && k < 20) begin
            cyc(1);
            k++;
        end
        chk("rst_low_cycles", k, RST_CYCLES);
    endtask

    task automatic wait_done(input int bound);
        int k;
        k = 0;
        while (!done && k < bound) begin
            cyc(1);
            k++;
        end
        chk("done_within_bound", {63'd0, done}, 64'd1);
    endtask

    // Monitor: compare every completed run against the queued expectation.
    initial begin
        logic done_q;
        exp_t e;
        done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_q) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_result", result, e.res);
                    chk("sb_cycle_count", cycle_count, e.cnt);
                    chk("sb_core_en_halted", {63'd0, core_en}, 64'd0);
                end
            end
            done_q = done;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; step_mode = 1'b0; step = 1'b0;
        pass_addr = 32'd0; fail_addr = 32'd0; pc = 32'd0;
        #22;
        chk("rst_core_rst_n", {63'd0, core_rst_n}, 64'd0);
        chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_count", cycle_count, 64'd0);
        chk("rst_leds", leds, 64'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);

        // PASS on RUN cycle 10
        start_run(32'h40, 32'h80);
        chk("run_core_en", {63'd0, core_en}, 64'd1);
        chk("run_busy", {63'd0, busy}, 64'd1);
        chk("run_leds", leds, 64'h3D);
        cyc(9);
        pc = 32'h40;
        push(2'd1, 32'd10);
        cyc(1);
        pc = 32'd0;
        chk("pass_leds", leds, 64'h2C);

        // restart straight from PASS, FAIL on cycle 5
        start_run(32'h40, 32'h80);
        cyc(4);
        pc = 32'h80;
        push(2'd2, 32'd5);
        cyc(1);
        pc = 32'd0;

        // equal pass/fail addresses resolve to FAIL
        start_run(32'h20, 32'h20);
        cyc(2);
        pc = 32'h20;
        push(2'd2, 32'd3);
        cyc(1);
        pc = 32'd0;

        // no match: TIMEOUT at the limit
        start_run(32'h40, 32'h80);
        push(2'd3, 32'd1000);
        wait_done(1100);
        chk("timeout_leds", leds, 64'h0A);

        // match on the limit cycle wins over TIMEOUT
        start_run(32'h40, 32'h80);
        cyc(999);
        pc = 32'h40;
        push(2'd1, 32'd1000);
        cyc(1);
        pc = 32'd0;

        // single-step: three step pulses over 50 cycles, a stray start ignored
        step_mode = 1'b1;
        start_run(32'h40, 32'h80);
        en_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            step = (i == 5 || i == 20 || i == 35);
            start = (i == 25);
            #1;
            if (core_en) en_cnt++;
            cyc(1);
        end
        step = 1'b0;
        start = 1'b0;
        chk("step_en_cycles", en_cnt, 64'd3);
        chk("step_count", cycle_count, 64'd3);
        chk("step_still_run", {61'd0, busy, done, core_rst_n}, 64'b101);
        chk("step_idle_en", {63'd0, core_en}, 64'd0);

        // clear aborts a run
        step_mode = 1'b0;
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("clear_run_outs", {60'd0, core_rst_n, core_en, busy, done}, 64'd0);
        chk("clear_run_result", result, 64'd0);
        chk("clear_run_leds", leds, 64'h3F);

        // clear and start together in PASS: clear wins
        start_run(32'h40, 32'h80);
        pc = 32'h40;
        push(2'd1, 32'd1);
        cyc(1);
        pc = 32'd0;
        start = 1'b1;
        clear = 1'b1;
        cyc(1);
        start = 1'b0;
        clear = 1'b0;
        chk("clrstart_outs", {61'd0, core_rst_n, busy, done}, 64'd0);
        chk("clrstart_result", result, 64'd0);

        // asynchronous reset mid-RUN
        start_run(32'h40, 32'h80);
        cyc(5);
        rst_n = 1'b0;
        #2;
        chk("arst_outs", {60'd0, core_rst_n, core_en, busy, done}, 64'd0);
        chk("arst_result", result, 64'd0);
        chk("arst_count", cycle_count, 64'd0);
        chk("arst_leds", leds, 64'h3F);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);

        chk("sb_drained", sb_q.size(), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
